serial_ripple_subtractor: RTL and testbench
===========================================

// Module: serial_ripple_subtractor
// PURPOSE
//  Multi-cycle ripple subtractor: diff = a - b - bin, BITS_PER_CYCLE bits per clock.
//  Inverse datapath to the ripple-carry adder; borrow chain replaces carry chain.
//  The borrow is held in a flip-flop between steps.
//  Slots beside the adder in the arithmetic unit; valid/ready on both sides.
// PARAMETERS
//  WIDTH           32  operand/result width in bits
//  BITS_PER_CYCLE  1   bits resolved per clock; must divide WIDTH (elaboration error otherwise)
//  (derived) STEPS = WIDTH/BITS_PER_CYCLE; CNT_W = $clog2(STEPS+1)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operands a/b/bin valid
//  in_ready   out  1      block can accept operands (high only in IDLE)
//  a          in   WIDTH  minuend (unsigned/two's complement)
//  b          in   WIDTH  subtrahend
//  bin        in   1      borrow-in
//  out_valid  out  1      diff/bout/ovf valid (high only in DONE)
//  out_ready  in   1      consumer accepts result
//  diff       out  WIDTH  (a - b - bin) mod 2^WIDTH
//  bout       out  1      1 iff a < b + bin (unsigned)
//  ovf        out  1      signed overflow; present only with SUB_OVF_EN
// BEHAVIOUR
//  States: IDLE -> RUN -> DONE -> IDLE.
//  Reset: state=IDLE, count=0, borrow=0, diff=0, bout=0, ovf=0, out_valid=0; in_ready=0 while rst high.
//  IDLE: in_ready=1. On in_valid&&in_ready: latch a, b into shift regs; borrow<=bin; count<=0; -> RUN.
//  RUN: in_ready=0, out_valid=0. Each cycle: low BITS_PER_CYCLE bits of a/b pass through a chain of
//   1-bit subtractor cells seeded by borrow. Result bits shift into diff from the MSB end; a/b shift right.
//   borrow <= chain borrow-out; count++. When count reaches STEPS-1, go to DONE; bout <= final borrow.
//  Latency: accept at edge k -> out_valid high after edge k+STEPS (STEPS=32 default).
//  DONE: out_valid=1; diff/bout/ovf held stable until out_valid&&out_ready -> IDLE.
//  in_valid ignored outside IDLE. Min initiation interval STEPS+2 cycles; DONE->IDLE costs one bubble.
//  Wrap-around: arithmetic is modulo 2^WIDTH; no saturation.
//  Reset mid-RUN/DONE: operation discarded, no out_valid pulse, returns to IDLE next cycle.
//  diff/bout contents are don't-care while out_valid=0 (except the reset values).
// CONFIGURATION
//  SUB_OVF_EN defined: ovf port exists; latched on entry to DONE as
//   (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]), using the original operand MSBs
//   captured at accept; reset value 0; held with diff.
//  SUB_OVF_EN undefined: no ovf port, no MSB capture regs; all other behaviour identical.
// STRUCTURE
//  Package arith_pkg: state enum {IDLE, RUN, DONE} (2-bit encoding) and a WIDTH default constant,
//   shared with the adder.
//  Sub-module full_subtractor (a, b, bin -> d, bout): d = a^b^bin, bout = (~a&b)|(~(a^b)&bin).
//   BITS_PER_CYCLE instances are chained per step.
//  Top level: FSM, step counter, a/b/diff shift registers, borrow FF.
// TESTING (WIDTH=32 unless noted)
//  1 a=0x00000005, b=0x00000003, bin=0 -> diff=0x00000002, bout=0; out_valid exactly 32 cycles after accept.
//  2 a=0x00000000, b=0x00000001, bin=0 -> diff=0xFFFFFFFF, bout=1 (wrap-around).
//  3 SUB_OVF_EN: a=0x80000000, b=0x00000001 -> diff=0x7FFFFFFF, bout=0, ovf=1;
//    a=5, b=3 -> ovf=0.
//  4 Backpressure: out_ready=0 for 5 cycles in DONE -> diff/bout stable, in_ready=0, in_valid pulses ignored;
//    then out_ready=1 -> IDLE next cycle.
//  5 rst asserted on the 10th RUN cycle -> IDLE, out_valid never rises; next op a=9, b=4 -> diff=5.
//  6 BITS_PER_CYCLE=4: a=0xFFFFFFFF, b=0xFFFFFFFF, bin=1 -> diff=0xFFFFFFFF, bout=1; latency 8 cycles.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared definitions for the serial arithmetic unit (adder and subtractor).
package arith_pkg;

    localparam int unsigned DefaultWidth = 32;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } arith_state_e;

endpackage

// File: rtl/serial_ripple_subtractor_if.sv
// Operand/result handshake bundle for the serial subtractor.
// The ovf signal exists only when SUB_OVF_EN is defined.
interface serial_ripple_subtractor_if
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SUB_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout
`ifdef SUB_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout
`ifdef SUB_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/full_subtractor.sv
// One-bit subtractor cell: d = a - b - bin, bout is the borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_ripple_subtractor.sv
// Multi-cycle ripple subtractor, BITS_PER_CYCLE bits per clock, borrow held in a flop.
// Optional signed-overflow output enabled by defining SUB_OVF_EN.
module serial_ripple_subtractor
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH          = DefaultWidth,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input logic                         clk,
    input logic                         rst,
    serial_ripple_subtractor_if.slave   bus
);
    localparam int unsigned STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = $clog2(STEPS + 1);
    localparam logic [CNT_W-1:0] LastStep = CNT_W'(STEPS - 1);

    if (BITS_PER_CYCLE == 0 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
        $error("BITS_PER_CYCLE must be nonzero and divide WIDTH");
    end

    arith_state_e        state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [WIDTH-1:0]    a_q, b_q, diff_q;
    logic                borrow_q, bout_q, out_valid_q;
    logic [BITS_PER_CYCLE:0]   chain;
    logic [BITS_PER_CYCLE-1:0] step_d;
    logic [WIDTH-1:0]    diff_next;
`ifdef SUB_OVF_EN
    logic                a_msb_q, b_msb_q, ovf_q;
`endif

    assign chain[0] = borrow_q;

    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_cell
        full_subtractor u_cell (
            .a    (a_q[i]),
            .b    (b_q[i]),
            .bin  (chain[i]),
            .d    (step_d[i]),
            .bout (chain[i+1])
        );
    end

    // New result bits enter at the MSB end so the word is aligned after STEPS shifts.
    assign diff_next = (diff_q >> BITS_PER_CYCLE) | (WIDTH'(step_d) << (WIDTH - BITS_PER_CYCLE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
            bout_q      <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef SUB_OVF_EN
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        a_q      <= bus.a;
                        b_q      <= bus.b;
                        borrow_q <= bus.bin;
                        cnt_q    <= '0;
                        state_q  <= StRun;
`ifdef SUB_OVF_EN
                        a_msb_q  <= bus.a[WIDTH-1];
                        b_msb_q  <= bus.b[WIDTH-1];
`endif
                    end
                end
                StRun: begin
                    a_q      <= a_q >> BITS_PER_CYCLE;
                    b_q      <= b_q >> BITS_PER_CYCLE;
                    diff_q   <= diff_next;
                    borrow_q <= chain[BITS_PER_CYCLE];
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == LastStep) begin
                        bout_q      <= chain[BITS_PER_CYCLE];
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
`ifdef SUB_OVF_EN
                        ovf_q <= (a_msb_q != b_msb_q) && (step_d[BITS_PER_CYCLE-1] != a_msb_q);
`endif
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Gated by rst so the block never advertises readiness while being reset.
    assign bus.in_ready  = (state_q == StIdle) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
`ifdef SUB_OVF_EN
    assign bus.ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Bench for serial_ripple_subtractor: a 1-bit/cycle and a 4-bit/cycle instance driven in lockstep.
module tb_serial_ripple_subtractor;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] drv_a, drv_b;
    logic        drv_bin;

    int checks   = 0;
    int failures = 0;

    serial_ripple_subtractor_if #(.WIDTH(32)) ifc0 ();
    serial_ripple_subtractor_if #(.WIDTH(32)) ifc4 ();

    assign ifc0.in_valid  = in_valid;
    assign ifc0.a         = drv_a;
    assign ifc0.b         = drv_b;
    assign ifc0.bin       = drv_bin;
    assign ifc0.out_ready = out_ready;
    assign ifc4.in_valid  = in_valid;
    assign ifc4.a         = drv_a;
    assign ifc4.b         = drv_b;
    assign ifc4.bin       = drv_bin;
    assign ifc4.out_ready = out_ready;

    serial_ripple_subtractor #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (ifc0.slave)
    );

    serial_ripple_subtractor #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (ifc4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [31:0] d0;
        logic        bo0;
        logic        ov0;
        int          lat0;
        logic [31:0] d4;
        logic        bo4;
        logic        ov4;
        int          lat4;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        bin;
        logic [31:0] exp_diff;
        logic        exp_bout;
        logic        exp_ovf;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: plain modular arithmetic and an unsigned comparison.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic bin,
                                  output logic [31:0] d, output logic bo, output logic ov);
        longint unsigned ua, ub;
        ua = 64'(a);
        ub = 64'(b) + 64'(bin);
        d  = a - b - 32'(bin);
        bo = (ua < ub);
        ov = (a[31] != b[31]) && (d[31] != a[31]);
    endfunction

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_, input logic tbin,
                          output res_t r);
        int n;
        n = 0;
        while (!ifc0.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", 64'(ifc0.in_ready), 64'd1);
        drv_a    = ta;
        drv_b    = tb_;
        drv_bin  = tbin;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        drv_a    = $urandom;
        drv_b    = $urandom;
        drv_bin  = 1'($urandom);
        n      = 0;
        r.lat4 = -1;
        while (!ifc0.out_valid && n < 200) begin
            if (ifc4.out_valid && r.lat4 < 0) r.lat4 = n;
            @(negedge clk);
            n++;
        end
        if (ifc4.out_valid && r.lat4 < 0) r.lat4 = n;
        r.lat0 = n;
        r.d0   = ifc0.diff;
        r.bo0  = ifc0.bout;
        r.d4   = ifc4.diff;
        r.bo4  = ifc4.bout;
`ifdef SUB_OVF_EN
        r.ov0  = ifc0.ovf;
        r.ov4  = ifc4.ovf;
`else
        r.ov0  = 1'b0;
        r.ov4  = 1'b0;
`endif
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_after_hs.in_ready", 64'(ifc0.in_ready), 64'd1);
        check("idle_after_hs.out_valid", 64'(ifc0.out_valid), 64'd0);
    endtask

    task automatic check_res(input string tag, input res_t r, input logic [31:0] ed,
                             input logic eb, input logic eo);
        check({tag, ".diff1"}, 64'(r.d0), 64'(ed));
        check({tag, ".bout1"}, 64'(r.bo0), 64'(eb));
        check({tag, ".lat1"}, 64'(r.lat0), 64'd32);
        check({tag, ".diff4"}, 64'(r.d4), 64'(ed));
        check({tag, ".bout4"}, 64'(r.bo4), 64'(eb));
        check({tag, ".lat4"}, 64'(r.lat4), 64'd8);
`ifdef SUB_OVF_EN
        check({tag, ".ovf1"}, 64'(r.ov0), 64'(eo));
        check({tag, ".ovf4"}, 64'(r.ov4), 64'(eo));
`else
        if (eo === 1'bx) check({tag, ".ovf"}, 64'(r.ov0), 64'(eo));
`endif
    endtask

    initial begin
        vec_t        vecs[8];
        res_t        r;
        logic [31:0] ed, held_d;
        logic        eb, eo, held_b, seen;

        vecs[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0};
        vecs[1] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[2] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1};
        vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[4] = '{32'h0000_0009, 32'h0000_0004, 1'b0, 32'h0000_0005, 1'b0, 1'b0};
        vecs[5] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[6] = '{32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        vecs[7] = '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 32'h4B4B_4B4B, 1'b0, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drv_a     = '0;
        drv_b     = '0;
        drv_bin   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.in_ready", 64'(ifc0.in_ready), 64'd0);
        check("reset.out_valid", 64'(ifc0.out_valid), 64'd0);
        check("reset.diff", 64'(ifc0.diff), 64'd0);
        check("reset.bout", 64'(ifc0.bout), 64'd0);
        check("reset.diff4", 64'(ifc4.diff), 64'd0);
`ifdef SUB_OVF_EN
        check("reset.ovf", 64'(ifc0.ovf), 64'd0);
`endif
        rst = 1'b0;
        @(negedge clk);
        check("post_reset.in_ready", 64'(ifc0.in_ready), 64'd1);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, r);
            check_res($sformatf("vec%0d", i), r, vecs[i].exp_diff, vecs[i].exp_bout,
                      vecs[i].exp_ovf);
            finish_op();
        end

        // Backpressure: result held for 5 stalled cycles while in_valid pulses are ignored.
        run_op(32'h0000_1000, 32'h0000_0001, 1'b0, r);
        check_res("bp", r, 32'h0000_0FFF, 1'b0, 1'b0);
        held_d = ifc0.diff;
        held_b = ifc0.bout;
        for (int c = 0; c < 5; c++) begin
            in_valid = c[0] ? 1'b0 : 1'b1;
            drv_a    = $urandom;
            drv_b    = $urandom;
            @(negedge clk);
            check("bp.diff_stable", 64'(ifc0.diff), 64'(held_d));
            check("bp.bout_stable", 64'(ifc0.bout), 64'(held_b));
            check("bp.out_valid", 64'(ifc0.out_valid), 64'd1);
            check("bp.in_ready", 64'(ifc0.in_ready), 64'd0);
        end
        in_valid = 1'b0;
        finish_op();

        // Reset on the 10th RUN cycle discards the operation.
        drv_a    = 32'h0000_0055;
        drv_b    = 32'h0000_0022;
        drv_bin  = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst.in_ready_low", 64'(ifc0.in_ready), 64'd0);
        check("midrst.out_valid", 64'(ifc0.out_valid), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst.in_ready_idle", 64'(ifc0.in_ready), 64'd1);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ifc0.out_valid) seen = 1'b1;
        end
        check("midrst.no_out_valid", 64'(seen), 64'd0);
        run_op(32'd9, 32'd4, 1'b0, r);
        check_res("after_rst", r, 32'd5, 1'b0, 1'b0);
        finish_op();

        // Randomised operands against the arithmetic model.
        for (int i = 0; i < 12; i++) begin
            logic [31:0] ra, rb;
            logic        rbin;
            ra   = $urandom;
            rb   = (i % 4 == 3) ? ra : $urandom;
            rbin = 1'($urandom_range(0, 1));
            model(ra, rb, rbin, ed, eb, eo);
            run_op(ra, rb, rbin, r);
            check_res($sformatf("rand%0d", i), r, ed, eb, eo);
            finish_op();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
